win_cmd_gen: RTL and testbench

//  Upstream command source for the cursor/window controller. Takes raw push-buttons, and outputs the
//  7-bit window-control command bus consumed by the cursor/window controller.
//  Per-button processing: 2-FF synchronisation, debounce, single-cycle press pulses, hold-to-auto-repeat.

---
 rtl/win_cmd_gen.sv | 70 +++++++
 tb/tb_win_cmd_gen.sv | 89 ++++++++
 2 files changed

// File: rtl/win_cmd_gen.sv
// win_cmd_gen: turns raw push-buttons into debounced, auto-repeating window-control command pulses
module win_cmd_gen #(
  parameter int CNT_W = 24,
  parameter logic [CNT_W-1:0] DB_CYCLES = CNT_W'(50000),
  parameter logic [CNT_W-1:0] REP_DELAY = CNT_W'(5000000),
  parameter logic [CNT_W-1:0] REP_PERIOD = CNT_W'(1500000)
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [5:0] btn_raw,
  input  logic       btn_mode,
  input  logic       run_mode,
  output logic [6:0] cmd,
  output logic       mode_led
);
  localparam logic [CNT_W-1:0] DB_LIM = DB_CYCLES - CNT_W'(1);
  localparam logic [CNT_W-1:0] DLY_LIM = REP_DELAY - CNT_W'(1);
  localparam logic [CNT_W-1:0] PER_LIM = REP_PERIOD - CNT_W'(1);
  logic [6:0] w_raw, r_s1, r_s2, r_db, r_db_d, w_rise;
  logic [CNT_W-1:0] r_dbc [7];
  logic [CNT_W-1:0] r_rep [4];
  logic [3:0] r_ph, w_hit;
  logic [5:0] r_pls;
  logic r_mode;
  assign w_raw = {btn_mode, btn_raw};
  assign w_rise = r_db & ~r_db_d;
  // a repeat fires when the held button's counter hits the delay limit, then the period limit
  always_comb begin
    w_hit = '0;
    for (int k = 0; k < 4; k++)
      w_hit[k] = r_db[k] & ~w_rise[k] & (r_rep[k] == (r_ph[k] ? PER_LIM : DLY_LIM));
  end
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_s1 <= '0;
      r_s2 <= '0;
      r_db <= '0;
      r_db_d <= '0;
      r_pls <= '0;
      r_mode <= 1'b0;
      r_ph <= '0;
      for (int k = 0; k < 7; k++) r_dbc[k] <= '0;
      for (int k = 0; k < 4; k++) r_rep[k] <= '0;
    end else begin
      r_s1 <= w_raw;
      r_s2 <= r_s1;
      r_db_d <= r_db;
      r_pls <= w_rise[5:0] | {2'b00, w_hit};
      r_mode <= r_mode ^ w_rise[6];
      for (int k = 0; k < 7; k++) begin
        if (r_s2[k] == r_db[k]) r_dbc[k] <= '0;
        else if (r_dbc[k] == DB_LIM) begin
          r_dbc[k] <= '0;
          r_db[k] <= ~r_db[k];
        end else r_dbc[k] <= r_dbc[k] + CNT_W'(1);
      end
      for (int k = 0; k < 4; k++) begin
        if (!r_db[k] || w_rise[k]) begin
          r_rep[k] <= '0;
          r_ph[k] <= 1'b0;
        end else if (w_hit[k]) begin
          r_rep[k] <= '0;
          r_ph[k] <= 1'b1;
        end else r_rep[k] <= r_rep[k] + CNT_W'(1);
      end
    end
  end
  assign cmd = {r_mode | run_mode, r_pls};
  assign mode_led = r_mode;
endmodule

// File: tb/tb_win_cmd_gen.sv
// tb_win_cmd_gen: directed checks of debounce, press pulse, auto-repeat, mode toggle and reset
module tb_win_cmd_gen;
  logic clk = 1'b0;
  logic rst;
  logic [5:0] btn_raw;
  logic btn_mode, run_mode;
  logic [6:0] cmd;
  logic mode_led;
  int n_run = 0;
  int n_fail = 0;
  win_cmd_gen #(.CNT_W(24), .DB_CYCLES(24'd4), .REP_DELAY(24'd10), .REP_PERIOD(24'd5)) dut (
    .clk(clk), .rst(rst), .btn_raw(btn_raw), .btn_mode(btn_mode),
    .run_mode(run_mode), .cmd(cmd), .mode_led(mode_led)
  );
  always #5 clk = ~clk;
  task automatic tick();
    @(posedge clk);
    #1;
  endtask
  task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] exp);
    n_run++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask
  // raw high for edges 1..h: press pulse at edge 7, repeats at 17,22,... while debounced high (through edge h+6)
  task automatic hold(input logic [5:0] m, input int h, input int n, input string tag);
    logic [5:0] e6;
    btn_raw = m;
    for (int e = 1; e <= n; e++) begin
      tick();
      e6 = '0;
      if (h >= 4 && e == 7) e6 = m;
      if (h >= 4 && e >= 17 && e <= h + 6 && (e - 17) % 5 == 0) e6 = m & 6'h0F;
      chk($sformatf("%s@%0d", tag, e), {2'b00, cmd[5:0]}, {2'b00, e6});
      if (e == h) btn_raw = '0;
    end
  endtask
  task automatic mpress(input logic b, input string tag);
    logic m;
    btn_mode = 1'b1;
    for (int e = 1; e <= 20; e++) begin
      tick();
      m = (e >= 7) ? ~b : b;
      chk($sformatf("%s@%0d", tag, e), {cmd[6], mode_led, cmd[5:0]}, {m | run_mode, m, 6'h00});
      if (e == 10) btn_mode = 1'b0;
    end
  endtask
  initial begin
    rst = 1'b0;
    btn_raw = 6'h3F;
    btn_mode = 1'b0;
    run_mode = 1'b0;
    tick();
    tick();
    tick();
    chk("reset", {cmd, mode_led}, 8'h00);
    rst = 1'b1;
    hold(6'h3F, 25, 40, "all_held");
    hold(6'h01, 3, 15, "glitch");
    hold(6'h04, 40, 55, "repeat");
    hold(6'h10, 40, 55, "zoom");
    mpress(1'b0, "mode1");
    mpress(1'b1, "mode2");
    run_mode = 1'b1;
    #1;
    chk("run_force", {cmd[6], mode_led}, 8'h02);
    mpress(1'b0, "run_mode1");
    mpress(1'b1, "run_mode2");
    run_mode = 1'b0;
    btn_raw = 6'h08;
    for (int e = 1; e <= 7; e++) begin
      tick();
      chk($sformatf("pre_rst@%0d", e), {2'b00, cmd[5:0]}, (e == 7) ? 8'h08 : 8'h00);
    end
    rst = 1'b0;
    #1;
    chk("rst_drop", {cmd, mode_led}, 8'h00);
    for (int e = 1; e <= 3; e++) begin
      tick();
      chk($sformatf("in_rst@%0d", e), {cmd, mode_led}, 8'h00);
    end
    rst = 1'b1;
    hold(6'h08, 20, 30, "post_rst");
    $display("[TB] %0d tests run, %0d failed", n_run, n_fail);
    $finish;
  end
endmodule
